// File: rtl/dice_pkg.sv
// Shared definitions for the dice game round controller.
// Holds the state encoding, the result codes and the legal die range.
package dice_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ROLL1    = 3'd1,
    ST_WAIT2    = 3'd2,
    ST_ROLL2    = 3'd3,
    ST_COMPARE  = 3'd4,
    ST_SHOW     = 3'd5,
    ST_GAMEOVER = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_P1   = 2'd1,
    RES_P2   = 2'd2,
    RES_TIE  = 2'd3
  } result_t;

  localparam logic [3:0] DICE_MIN = 4'd1;
  localparam logic [3:0] DICE_MAX = 4'd6;

  function automatic logic die_in_range(input logic [3:0] v);
    return (v >= DICE_MIN) && (v <= DICE_MAX);
  endfunction

endpackage

// File: rtl/dice_btn_edge.sv
// Button history flop plus rising-edge detect.
// History resets to 1 so a button held through reset must be released first.
module dice_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic btn_q;

  always_ff @(posedge clk) begin
    if (rst) btn_q <= 1'b1;
    else     btn_q <= btn;
  end

  assign press = btn & ~btn_q;

endmodule

// File: rtl/dice_round_ctrl.sv
// Round sequencer for the two-player dice game: roll enables, die latching,
// round comparison, first-to-WIN_SCORE scoring and game-over handling.
module dice_round_ctrl
  import dice_pkg::*;
#(
  parameter int WIN_SCORE      = 3,
  parameter int MIN_ROLL_TICKS = 2,
  parameter int SHOW_TICKS     = 4,
  parameter int SCORE_W        = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start1,
  input  logic               start2,
  input  logic [3:0]         dice1_val,
  input  logic [3:0]         dice2_val,
  output logic               roll1_en,
  output logic               roll2_en,
  output logic [3:0]         held1,
  output logic [3:0]         held2,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         result,
  output logic               round_done,
  output logic               game_over,
  output logic               err,
  output logic [2:0]         state
);

  localparam int CNT_MAX = (MIN_ROLL_TICKS > SHOW_TICKS) ? MIN_ROLL_TICKS : SHOW_TICKS;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]   ROLL_LIM = CNT_W'(MIN_ROLL_TICKS);
  localparam logic [CNT_W-1:0]   SHOW_LIM = CNT_W'(SHOW_TICKS);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  result_t          result_q;
  logic             press1, press2;
  logic             latch1, latch2, do_cmp, clr_game;

  dice_btn_edge u_btn1 (.clk(clk), .rst(rst), .btn(start1), .press(press1));
  dice_btn_edge u_btn2 (.clk(clk), .rst(rst), .btn(start2), .press(press2));

  // Tick counting saturates at the limit so exit tests stay simple.
  function automatic logic [CNT_W-1:0] count_tick(input logic t,
                                                  input logic [CNT_W-1:0] c,
                                                  input logic [CNT_W-1:0] lim);
    return (t && (c < lim)) ? c + 1'b1 : c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    latch1   = 1'b0;
    latch2   = 1'b0;
    do_cmp   = 1'b0;
    clr_game = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press1) begin
          state_n = ST_ROLL1;
          cnt_n   = '0;
        end
      end
      // The tick is folded into the count before the release is judged.
      ST_ROLL1: begin
        cnt_n = count_tick(tick, cnt_q, ROLL_LIM);
        if (!start1 && (cnt_n >= ROLL_LIM)) begin
          state_n = ST_WAIT2;
          latch1  = 1'b1;
        end
      end
      ST_WAIT2: begin
        if (press2) begin
          state_n = ST_ROLL2;
          cnt_n   = '0;
        end
      end
      ST_ROLL2: begin
        cnt_n = count_tick(tick, cnt_q, ROLL_LIM);
        if (!start2 && (cnt_n >= ROLL_LIM)) begin
          state_n = ST_COMPARE;
          latch2  = 1'b1;
        end
      end
      ST_COMPARE: begin
        do_cmp  = 1'b1;
        cnt_n   = '0;
        state_n = ST_SHOW;
      end
      ST_SHOW: begin
        cnt_n = count_tick(tick, cnt_q, SHOW_LIM);
        if (cnt_n >= SHOW_LIM)
          state_n = ((score1 == WIN) || (score2 == WIN)) ? ST_GAMEOVER : ST_IDLE;
      end
      ST_GAMEOVER: begin
        if (press1 || press2) begin
          state_n  = ST_IDLE;
          clr_game = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Out-of-range dice are replaced by the minimum face and flagged in err.
  always_ff @(posedge clk) begin
    if (rst) begin
      held1      <= '0;
      held2      <= '0;
      score1     <= '0;
      score2     <= '0;
      result_q   <= RES_NONE;
      round_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      round_done <= do_cmp;
      if (latch1) begin
        held1 <= die_in_range(dice1_val) ? dice1_val : DICE_MIN;
        if (!die_in_range(dice1_val)) err <= 1'b1;
      end
      if (latch2) begin
        held2 <= die_in_range(dice2_val) ? dice2_val : DICE_MIN;
        if (!die_in_range(dice2_val)) err <= 1'b1;
      end
      if (do_cmp) begin
        if (held1 > held2) begin
          result_q <= RES_P1;
          if (score1 < WIN) score1 <= score1 + 1'b1;
        end else if (held2 > held1) begin
          result_q <= RES_P2;
          if (score2 < WIN) score2 <= score2 + 1'b1;
        end else begin
          result_q <= RES_TIE;
        end
      end
      if (clr_game) begin
        held1    <= '0;
        held2    <= '0;
        score1   <= '0;
        score2   <= '0;
        result_q <= RES_NONE;
      end
    end
  end

  assign roll1_en  = (state_q == ST_ROLL1);
  assign roll2_en  = (state_q == ST_ROLL2);
  assign game_over = (state_q == ST_GAMEOVER);
  assign result    = result_q;
  assign state     = state_q;

endmodule

// File: doc/dice_round_ctrl.md
Name: dice_round_ctrl

Overview:
Round sequencer for the two-player dice game. Turns the player buttons into per-player roll enables for the random dice generators and latches each player's final die. It then compares the two dice, keeps a first-to-WIN_SCORE score, and publishes result, score and game-over status to the matrix, 7-segment and RGB display logic. It sits between the button inputs, the divided-clock tick, and the roll/display datapath.

Parameters:
WIN_SCORE, 3, rounds needed to win the game (1..15)
MIN_ROLL_TICKS, 2, minimum ticks a die rolls once started, even if the button is released earlier
SHOW_TICKS, 4, ticks the round result is held before the next round is accepted
SCORE_W, 4, width of the score counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tick  in  1  one-cycle enable from the clock divider; all timing counts ticks
start1  in  1  player 1 button, debounced level
start2  in  1  player 2 button, debounced level
dice1_val  in  4  current value of player 1 random generator
dice2_val  in  4  current value of player 2 random generator
roll1_en  out  1  enables player 1 generator
roll2_en  out  1  enables player 2 generator
held1  out  4  latched final die of player 1
held2  out  4  latched final die of player 2
score1  out  SCORE_W  player 1 score
score2  out  SCORE_W  player 2 score
result  out  2  0=NONE, 1=P1 wins, 2=P2 wins, 3=TIE
round_done  out  1  one-cycle pulse when result/scores update
game_over  out  1  high while in GAMEOVER
err  out  1  sticky: an out-of-range die was latched
state  out  3  FSM state, for display/debug

Behaviour:
- Reset (clk edge with rst=1) clears all outputs to 0; result=NONE; state=IDLE; tick counter=0.
- Reset sets the button-history flops to 1, so a button held through reset needs release and re-press. Reset mid-round aborts with no score change.
- Press = rising edge (start & ~start_q), one cycle, evaluated every clk.
- States: IDLE, ROLL1, WAIT2, ROLL2, COMPARE, SHOW, GAMEOVER.
- IDLE: press1 -> ROLL1 and clear the tick counter. press2 in IDLE is ignored, because player 1 always rolls first. If press1 and press2 occur in the same cycle, go to ROLL1 and drop press2.
- ROLL1: roll1_en=1 (decoded from state, high exactly while in ROLL1). Count ticks, saturating at MIN_ROLL_TICKS.
- Leave ROLL1 on the first cycle where start1=0 and count>=MIN_ROLL_TICKS. On that edge held1<=dice1_val and the state moves to WAIT2. Button activity on the other player is ignored.
- WAIT2: press2 -> ROLL2 with the tick counter cleared. press1 is ignored.
- ROLL2: mirrors ROLL1 using start2, dice2_val, roll2_en and held2, then -> COMPARE.
- Latch rule: a die outside 1..6 is stored as 1 and sets err. err clears only on rst.
- COMPARE (exactly 1 cycle): on exit edge:
  - held1>held2: score1+1, result=P1
  - held2>held1: score2+1, result=P2
  - equal: result=TIE, no score change
  - round_done=1 for the single following cycle; tick counter cleared; -> SHOW
- Scores saturate at WIN_SCORE.
- SHOW: count SHOW_TICKS ticks. At the count:
  - if score1==WIN_SCORE or score2==WIN_SCORE -> GAMEOVER
  - else -> IDLE
  - result, held1 and held2 are kept.
  - Presses during SHOW are discarded, not queued.
- GAMEOVER: game_over=1. Any press clears scores, held values and result (to NONE), then -> IDLE. game_over falls on the same edge.
- A tick and a button release in the same cycle: the tick is counted first, then the exit condition is evaluated on the updated count.
- Latency: press -> roll_en high is 1 clk. Exit condition -> held valid is 1 clk.

Decomposition:
- Shared package dice_pkg: state encoding, result codes (RES_NONE/P1/P2/TIE), DICE_MIN=1, DICE_MAX=6.
- Sub-module dice_btn_edge: the button-history flop with reset-to-1 plus rising-edge detect. Instantiated twice.
- FSM, tick counter and scoring live in dice_round_ctrl.

Test Plan:
Setup: WIN_SCORE=3, MIN_ROLL_TICKS=2, SHOW_TICKS=4, tick every 10 clk.
1. Hold start1 through reset, then keep it high -> state stays IDLE, roll1_en=0. Release and re-press -> ROLL1 one clk later.
2. press1, release after 1 tick -> roll1_en stays 1 until the 2nd tick. On exit held1 equals dice1_val at that cycle; state=WAIT2.
3. Round with dice1_val=5, dice2_val=3 -> result=1, score1=1, round_done high exactly 1 clk; IDLE after 4 ticks. press1 during SHOW is ignored.
4. Tie 4/4 -> result=3, scores unchanged. dice1_val=7 -> held1=1, err=1 and remains 1.
5. P2 wins three rounds -> score2=3, game_over=1, state=GAMEOVER. press2 -> scores=0, result=0, game_over=0, IDLE.
6. start1 and start2 rise in the same IDLE cycle -> ROLL1 only, roll2_en=0. Assert rst during ROLL2 -> every output 0 and state IDLE on the next clk.
